ram_2p_be: RTL and testbench

RAM_2P_BE -- requirements
Module: ram_2p_be

---
 rtl/ram_2p_be.sv | 131 +++++++++++++
 tb/tb_ram_2p_be.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/ram_2p_be.sv
// Dual-port RAM with byte-lane writes on port A, a registered read-only port B,
// and a sequential power-up / on-demand clear that walks every word to zero.
module ram_2p_be #(
    parameter int WIDTH      = 32,
    parameter int DEPTH      = 256,
    parameter int ADDR_WIDTH = $clog2(DEPTH),
    parameter int LANE_W     = 8,
    localparam int NLANE     = WIDTH / LANE_W
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  clr_req,
    output logic                  ready,
    input  logic [ADDR_WIDTH-1:0] a_addr,
    input  logic                  a_wr_en,
    input  logic [NLANE-1:0]      a_be,
    input  logic [WIDTH-1:0]      a_din,
    output logic [WIDTH-1:0]      a_dout,
    input  logic                  b_en,
    input  logic [ADDR_WIDTH-1:0] b_addr,
    output logic [WIDTH-1:0]      b_dout,
    output logic                  b_valid,
    output logic                  dbg_state_o
);

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_READY = 1'b1
    } state_e;

    localparam logic [ADDR_WIDTH:0]   DEPTH_L  = (ADDR_WIDTH + 1)'(DEPTH);
    localparam logic [ADDR_WIDTH-1:0] LAST_PTR = ADDR_WIDTH'(DEPTH - 1);

    logic [WIDTH-1:0] mem [DEPTH];

    state_e                state_q;
    logic                  ready_q;
    logic [ADDR_WIDTH-1:0] clr_ptr_q;
    logic                  b_valid_q;
    logic [WIDTH-1:0]      b_dout_q;
    logic [WIDTH-1:0]      b_dout_d;

    logic             a_in_range;
    logic             b_in_range;
    logic             accept;
    logic             a_wr_go;
    logic             b_rd_go;
    logic [WIDTH-1:0] lane_mask;
    logic [WIDTH-1:0] a_word;
    logic [WIDTH-1:0] b_word;
    logic [WIDTH-1:0] a_merged;

    // Non-power-of-two depths leave a hole at the top of the address space.
    assign a_in_range = ({1'b0, a_addr} < DEPTH_L);
    assign b_in_range = ({1'b0, b_addr} < DEPTH_L);

    assign accept  = (state_q == ST_READY) && !clr_req;
    assign a_wr_go = accept && a_wr_en && a_in_range;
    assign b_rd_go = accept && b_en;

    always_comb begin
        lane_mask = '0;
        for (int i = 0; i < NLANE; i++) begin
            lane_mask[i*LANE_W +: LANE_W] = {LANE_W{a_be[i]}};
        end
    end

    assign a_word   = a_in_range ? mem[a_addr] : '0;
    assign b_word   = b_in_range ? mem[b_addr] : '0;
    assign a_merged = (a_word & ~lane_mask) | (a_din & lane_mask);

    // Port B sees a same-address port A write in the same cycle (write-first).
    always_comb begin
        b_dout_d = b_word;
        if (a_wr_go && (a_addr == b_addr)) begin
            b_dout_d = a_merged;
        end
    end

    always_ff @(posedge clk) begin
        if (state_q == ST_CLEAR) begin
            mem[clr_ptr_q] <= '0;
        end else if (a_wr_go) begin
            mem[a_addr] <= a_merged;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= ST_CLEAR;
            ready_q   <= 1'b0;
            clr_ptr_q <= '0;
            b_valid_q <= 1'b0;
            b_dout_q  <= '0;
        end else begin
            b_valid_q <= b_rd_go;
            if (b_rd_go) begin
                b_dout_q <= b_dout_d;
            end
            case (state_q)
                ST_CLEAR: begin
                    if (clr_ptr_q == LAST_PTR) begin
                        state_q   <= ST_READY;
                        ready_q   <= 1'b1;
                        clr_ptr_q <= '0;
                    end else begin
                        clr_ptr_q <= clr_ptr_q + ADDR_WIDTH'(1);
                    end
                end
                ST_READY: begin
                    if (clr_req) begin
                        state_q   <= ST_CLEAR;
                        ready_q   <= 1'b0;
                        clr_ptr_q <= '0;
                    end
                end
                default: begin
                    state_q <= ST_CLEAR;
                    ready_q <= 1'b0;
                end
            endcase
        end
    end

    assign ready       = ready_q;
    assign a_dout      = a_word;
    assign b_dout      = b_dout_q;
    assign b_valid     = b_valid_q;
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_ram_2p_be.sv
// Bench for ram_2p_be: a DEPTH=256 and a DEPTH=200 instance share stimulus and
// are checked each cycle against an array-based memory model.
module tb_ram_2p_be;

    localparam int W  = 32;
    localparam int NL = 4;
    localparam int AW = 8;

    logic          clk = 1'b0;
    logic          reset;
    logic          clr_req;
    logic          a_wr_en;
    logic          b_en;
    logic [AW-1:0] a_addr;
    logic [AW-1:0] b_addr;
    logic [NL-1:0] a_be;
    logic [W-1:0]  a_din;

    logic [1:0]        rdy;
    logic [1:0]        bv;
    logic [1:0]        dbg;
    logic [1:0][W-1:0] ad;
    logic [1:0][W-1:0] bd;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    ram_2p_be #(.WIDTH(32), .DEPTH(256), .LANE_W(8)) u_d0 (
        .clk(clk), .reset(reset), .clr_req(clr_req), .ready(rdy[0]),
        .a_addr(a_addr), .a_wr_en(a_wr_en), .a_be(a_be), .a_din(a_din), .a_dout(ad[0]),
        .b_en(b_en), .b_addr(b_addr), .b_dout(bd[0]), .b_valid(bv[0]),
        .dbg_state_o(dbg[0])
    );

    ram_2p_be #(.WIDTH(32), .DEPTH(200), .LANE_W(8)) u_d1 (
        .clk(clk), .reset(reset), .clr_req(clr_req), .ready(rdy[1]),
        .a_addr(a_addr), .a_wr_en(a_wr_en), .a_be(a_be), .a_din(a_din), .a_dout(ad[1]),
        .b_en(b_en), .b_addr(b_addr), .b_dout(bd[1]), .b_valid(bv[1]),
        .dbg_state_o(dbg[1])
    );

    // Reference model: words, remaining clear edges, port B registers.
    int         dep [2] = '{256, 200};
    logic [W-1:0] m_mem [2][256];
    int         m_left [2];
    logic       m_bv [2];
    logic [W-1:0] m_bd [2];

    typedef struct {
        logic          wr;
        logic [NL-1:0] be;
        logic [AW-1:0] aa;
        logic [W-1:0]  din;
        logic          ben;
        logic [AW-1:0] ba;
        logic [W-1:0]  a_pre;
        logic [W-1:0]  a_post;
        logic [W-1:0]  b_dout;
        logic          b_v;
    } vec_t;

    vec_t tbl [7];

    task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    function automatic logic [W-1:0] merge(input logic [W-1:0] old, input logic [W-1:0] din,
                                           input logic [NL-1:0] be);
        logic [W-1:0] mask = '0;
        for (int i = 0; i < NL; i++) begin
            if (be[i]) mask = mask | (32'hFF << (8 * i));
        end
        return (old & ~mask) | (din & mask);
    endfunction

    function automatic logic [W-1:0] m_rd(input int k, input int addr);
        return (addr < dep[k]) ? m_mem[k][addr] : '0;
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_left[k] = dep[k];
            m_bv[k]   = 1'b0;
            m_bd[k]   = '0;
        end
    endtask

    task automatic model_edge();
        logic [W-1:0] nb;
        for (int k = 0; k < 2; k++) begin
            if (m_left[k] > 0) begin
                m_mem[k][dep[k] - m_left[k]] = '0;
                m_left[k] = m_left[k] - 1;
                m_bv[k]   = 1'b0;
            end else if (clr_req) begin
                m_left[k] = dep[k];
                m_bv[k]   = 1'b0;
            end else begin
                if (b_en) begin
                    nb = m_rd(k, int'(b_addr));
                    if (a_wr_en && a_addr == b_addr && int'(b_addr) < dep[k]) nb = merge(nb, a_din, a_be);
                    m_bd[k] = nb;
                    m_bv[k] = 1'b1;
                end else begin
                    m_bv[k] = 1'b0;
                end
                if (a_wr_en && int'(a_addr) < dep[k])
                    m_mem[k][a_addr] = merge(m_mem[k][a_addr], a_din, a_be);
            end
        end
    endtask

    task automatic check_all();
        for (int k = 0; k < 2; k++) begin
            cmp($sformatf("ready%0d", k), 32'(rdy[k]), 32'(m_left[k] == 0));
            cmp($sformatf("b_valid%0d", k), 32'(bv[k]), 32'(m_bv[k]));
            cmp($sformatf("b_dout%0d", k), bd[k], m_bd[k]);
            if (m_left[k] == 0) cmp($sformatf("a_dout%0d@%0d", k, a_addr), ad[k], m_rd(k, int'(a_addr)));
        end
    endtask

    task automatic step();
        @(posedge clk);
        if (reset) model_edge();
        else model_reset();
        #1;
        check_all();
    endtask

    task automatic idle();
        clr_req = 1'b0; a_wr_en = 1'b0; b_en = 1'b0;
        a_be = '0; a_din = '0; a_addr = '0; b_addr = '0;
    endtask

    task automatic drive(input logic wr, input logic [AW-1:0] aa, input logic [W-1:0] din,
                         input logic [NL-1:0] be, input logic ben, input logic [AW-1:0] ba);
        a_wr_en = wr; a_addr = aa; a_din = din; a_be = be; b_en = ben; b_addr = ba;
    endtask

    // Edges until each instance shows ready, compared with the expected counts.
    task automatic clear_count(input string name, input int exp0, input int exp1);
        int n  = 0;
        int c0 = -1;
        int c1 = -1;
        while ((c0 < 0 || c1 < 0) && n < 2000) begin
            step();
            n++;
            if (c0 < 0 && rdy[0]) c0 = n;
            if (c1 < 0 && rdy[1]) c1 = n;
        end
        cmp({name, "_edges0"}, 32'(c0), 32'(exp0));
        cmp({name, "_edges1"}, 32'(c1), 32'(exp1));
    endtask

    task automatic scan();
        idle();
        for (int a = 0; a < 256; a++) begin
            a_addr = 8'(a);
            step();
        end
    endtask

    function automatic logic [AW-1:0] pick();
        if ($urandom_range(0, 3) == 0) return 8'($urandom_range(0, 255));
        return 8'($urandom_range(0, 7));
    endfunction

    initial begin
        tbl[0] = '{1'b1, 4'hF, 8'd5, 32'hDEADBEEF, 1'b0, 8'd0,   32'h00000000, 32'hDEADBEEF, 32'h00000000, 1'b0};
        tbl[1] = '{1'b1, 4'h5, 8'd5, 32'h11223344, 1'b0, 8'd0,   32'hDEADBEEF, 32'hDE22BE44, 32'h00000000, 1'b0};
        tbl[2] = '{1'b0, 4'h0, 8'd5, 32'h00000000, 1'b1, 8'd5,   32'hDE22BE44, 32'hDE22BE44, 32'hDE22BE44, 1'b1};
        tbl[3] = '{1'b1, 4'hF, 8'd9, 32'hAAAAAAAA, 1'b0, 8'd0,   32'h00000000, 32'hAAAAAAAA, 32'hDE22BE44, 1'b0};
        tbl[4] = '{1'b1, 4'h3, 8'd9, 32'h55555555, 1'b1, 8'd9,   32'hAAAAAAAA, 32'hAAAA5555, 32'hAAAA5555, 1'b1};
        tbl[5] = '{1'b1, 4'h0, 8'd9, 32'hFFFFFFFF, 1'b0, 8'd0,   32'hAAAA5555, 32'hAAAA5555, 32'hAAAA5555, 1'b0};
        tbl[6] = '{1'b0, 4'h0, 8'd0, 32'h00000000, 1'b1, 8'd128, 32'h00000000, 32'h00000000, 32'h00000000, 1'b1};

        idle();
        reset = 1'b1;
        #2 reset = 1'b0;
        #1;
        model_reset();
        for (int k = 0; k < 2; k++) begin
            cmp($sformatf("rst_ready%0d", k), 32'(rdy[k]), 32'd0);
            cmp($sformatf("rst_bvalid%0d", k), 32'(bv[k]), 32'd0);
            cmp($sformatf("rst_bdout%0d", k), bd[k], 32'd0);
        end
        step();
        step();
        @(negedge clk) reset = 1'b1;
        clear_count("init_clear", 256, 200);

        for (int i = 0; i < 7; i++) begin
            drive(tbl[i].wr, tbl[i].aa, tbl[i].din, tbl[i].be, tbl[i].ben, tbl[i].ba);
            #1;
            cmp($sformatf("tbl%0d_a_pre", i), ad[0], tbl[i].a_pre);
            step();
            cmp($sformatf("tbl%0d_a_post", i), ad[0], tbl[i].a_post);
            cmp($sformatf("tbl%0d_b_dout", i), bd[0], tbl[i].b_dout);
            cmp($sformatf("tbl%0d_b_valid", i), 32'(bv[0]), 32'(tbl[i].b_v));
        end

        // Out-of-range address on the DEPTH=200 instance.
        drive(1'b1, 8'd250, 32'h12345678, 4'hF, 1'b1, 8'd250);
        #1;
        cmp("oor_a_pre", ad[1], 32'd0);
        step();
        cmp("oor_a_post", ad[1], 32'd0);
        cmp("oor_b_dout", bd[1], 32'd0);
        cmp("oor_b_valid", 32'(bv[1]), 32'd1);
        cmp("oor_wf_d0", bd[0], 32'h12345678);
        scan();

        // Clear request in the same cycle as a write; second request mid-clear.
        drive(1'b1, 8'd3, 32'hCAFEF00D, 4'hF, 1'b0, 8'd0);
        step();
        drive(1'b0, 8'd3, 32'h0, 4'h0, 1'b1, 8'd3);
        step();
        clr_req = 1'b1;
        drive(1'b1, 8'd3, 32'hFFFFFFFF, 4'hF, 1'b1, 8'd3);
        step();
        cmp("clr_ready", 32'(rdy[0]), 32'd0);
        cmp("clr_b_valid", 32'(bv[0]), 32'd0);
        cmp("clr_b_hold", bd[0], 32'hCAFEF00D);
        cmp("clr_wr_suppr", ad[0], 32'hCAFEF00D);
        idle();
        for (int i = 0; i < 50; i++) step();
        clr_req = 1'b1;
        step();
        clr_req = 1'b0;
        clear_count("clr_again", 256 - 51, 200 - 51);
        scan();

        // Reset asserted between edges while clr_ptr = 100.
        drive(1'b1, 8'd7, 32'h0BADF00D, 4'hF, 1'b0, 8'd0);
        step();
        drive(1'b0, 8'd7, 32'h0, 4'h0, 1'b1, 8'd7);
        step();
        idle();
        clr_req = 1'b1;
        step();
        clr_req = 1'b0;
        for (int i = 0; i < 100; i++) step();
        cmp("pre_rst_bdout", bd[0], 32'h0BADF00D);
        #1 reset = 1'b0;
        #1;
        model_reset();
        for (int k = 0; k < 2; k++) begin
            cmp($sformatf("mid_rst_ready%0d", k), 32'(rdy[k]), 32'd0);
            cmp($sformatf("mid_rst_bvalid%0d", k), 32'(bv[k]), 32'd0);
            cmp($sformatf("mid_rst_bdout%0d", k), bd[k], 32'd0);
        end
        step();
        step();
        @(negedge clk) reset = 1'b1;
        clear_count("rst_clear", 256, 200);

        for (int i = 0; i < 800; i++) begin
            clr_req = ($urandom_range(0, 199) == 0);
            drive(1'($urandom_range(0, 1)), pick(), $urandom, 4'($urandom), 1'($urandom_range(0, 1)), pick());
            step();
        end
        idle();
        for (int i = 0; i < 300; i++) step();
        scan();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
